// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin stream mux family.
package rr_mux_pkg;

  localparam int unsigned DEF_N = 8;
  localparam int unsigned DEF_W = 1;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if (((n - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

  // Low bit of channel idx inside a flattened bus of w-bit slices.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// Handshake bundle for rr_mux_arb; RR_MUX_LOCK_EN adds the in_last/out_last pair.
interface rr_mux_arb_if
  import rr_mux_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W
);
  localparam int unsigned SEL_W = clog2(N);

  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [N*W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
`ifdef RR_MUX_LOCK_EN
  logic [N-1:0]     in_last;
  logic             out_last;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef RR_MUX_LOCK_EN
    input  in_last,
    output out_last,
`endif
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
`ifdef RR_MUX_LOCK_EN
    output in_last,
    input  out_last,
`endif
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned SEL_W = clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [SEL_W-1:0] idx_o
);

  always_comb begin
    int unsigned c;
    logic [SEL_W-1:0] ci;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      c = 32'(ptr_i) + k;
      if (c >= N) c = c - N;
      ci = SEL_W'(c);
      if (en_i && !found && req_i[ci]) begin
        found     = 1'b1;
        gnt_o[ci] = 1'b1;
        idx_o     = ci;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N-to-1 round-robin stream mux with registered output and channel index.
// Define RR_MUX_LOCK_EN to hold arbitration on a channel until its in_last beat.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_mux_arb_if.slave  bus
);

  localparam int unsigned SEL_W = clog2(N);

  logic [SEL_W-1:0] ptr_q, ptr_d, g_idx;
  logic [N-1:0]     req, gnt;
  logic             load_en, fire;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] ptr_next;

`ifdef RR_MUX_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic             out_last_q, out_last_d;

  always_comb begin
    req = bus.in_valid;
    if (lock_q) begin
      req            = '0;
      req[lock_ch_q] = bus.in_valid[lock_ch_q];
    end
  end
`else
  always_comb req = bus.in_valid;
`endif

  // Gating with rst_n keeps in_ready low for the whole reset window.
  assign load_en  = (!out_valid_q || bus.out_ready) && rst_n;
  assign fire     = |gnt;
  assign ptr_next = (g_idx == SEL_W'(N - 1)) ? '0 : g_idx + 1'b1;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .en_i  (load_en),
    .gnt_o (gnt),
    .idx_o (g_idx)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef RR_MUX_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last_q;
`endif
    if (load_en) out_valid_d = fire;
    if (fire) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (gnt[i]) out_data_d = bus.in_data[slice_lo(i, W) +: W];
      end
      out_sel_d = g_idx;
`ifdef RR_MUX_LOCK_EN
      out_last_d = bus.in_last[g_idx];
      lock_ch_d  = g_idx;
      lock_d     = !bus.in_last[g_idx];
      if (bus.in_last[g_idx]) ptr_d = ptr_next;
`else
      ptr_d = ptr_next;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef RR_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef RR_MUX_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign bus.in_ready  = gnt;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
`ifdef RR_MUX_LOCK_EN
  assign bus.out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb with N=8, W=8; lock scenario runs when RR_MUX_LOCK_EN is defined.
module tb_rr_mux_arb;

  logic clk;
  logic rst_n;
  int unsigned n_cmp;
  int unsigned n_err;

  rr_mux_arb_if #(.N(8), .W(8)) bus ();

  rr_mux_arb #(.N(8), .W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) bus.in_data[i*8 +: 8] = 8'h10 + 8'(i);
`ifdef RR_MUX_LOCK_EN
    bus.in_last = '0;
`endif

    // Reset window
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sel",   32'(bus.out_sel),   32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    rst_n = 1'b1;
    #1;
    check("first_grant_ready", 32'(bus.in_ready), 32'h01);

    // Fairness: all channels requesting, one beat per cycle
    for (int i = 0; i < 10; i++) begin
      tick();
      check("fair_valid", 32'(bus.out_valid), 32'd1);
      check("fair_sel",   32'(bus.out_sel),   32'(i % 8));
      check("fair_data",  32'(bus.out_data),  32'h10 + 32'(i % 8));
      check("fair_ready", 32'(bus.in_ready),  32'(8'h01 << ((i + 1) % 8)));
    end

    // Drain: no requests, output empties but holds data/sel
    bus.in_valid = 8'h00;
    tick();
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_sel",   32'(bus.out_sel),   32'd1);
    check("drain_data",  32'(bus.out_data),  32'h11);

    // Sparse/wrap: grant 5 (ptr->6), then channels 2 and 7
    bus.in_valid = 8'h20;
    tick();
    check("sp5_sel", 32'(bus.out_sel), 32'd5);
    bus.in_valid = 8'h84;
    #1;
    check("sp_ready7", 32'(bus.in_ready), 32'h80);
    tick();
    check("sp7_sel",  32'(bus.out_sel),  32'd7);
    check("sp7_data", 32'(bus.out_data), 32'h17);
    check("sp_ready2", 32'(bus.in_ready), 32'h04);
    bus.in_valid = 8'h04;
    tick();
    check("sp2_sel",  32'(bus.out_sel),  32'd2);
    check("sp2_data", 32'(bus.out_data), 32'h12);
    bus.in_valid = 8'h08;
    tick();
    check("sp3a_sel", 32'(bus.out_sel), 32'd3);
    // ptr is now 4; a lone request from channel 3 must still be granted
    check("sp3b_ready", 32'(bus.in_ready), 32'h08);
    tick();
    check("sp3b_sel",   32'(bus.out_sel),   32'd3);
    check("sp3b_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 8'h00;
    tick();
    check("sp_drain_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure with all channels requesting; ptr is 4
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b0;
    #1;
    check("bp_ready_empty", 32'(bus.in_ready), 32'h10);
    tick();
    check("bp_sel0", 32'(bus.out_sel), 32'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_sel",   32'(bus.out_sel),   32'd4);
      check("bp_data",  32'(bus.out_data),  32'h14);
      check("bp_ready", 32'(bus.in_ready),  32'h00);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_resume_ready", 32'(bus.in_ready), 32'h20);
    tick();
    check("bp_resume_sel",  32'(bus.out_sel),  32'd5);
    check("bp_resume_data", 32'(bus.out_data), 32'h15);

    // Asynchronous reset while a beat is stalled
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_sel",   32'(bus.out_sel),   32'd0);
    check("async_rst_ready", 32'(bus.in_ready),  32'd0);
    bus.in_valid  = 8'h00;
    bus.out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);

`ifdef RR_MUX_LOCK_EN
    // Lock: channel 1 sends three beats while channel 2 keeps requesting
    bus.in_valid = 8'h06;
    bus.in_last  = 8'h00;
    #1;
    check("lk_ready0", 32'(bus.in_ready), 32'h02);
    tick();
    check("lk_sel1",  32'(bus.out_sel),  32'd1);
    check("lk_last1", 32'(bus.out_last), 32'd0);
    check("lk_ready1", 32'(bus.in_ready), 32'h02);
    tick();
    check("lk_sel2",  32'(bus.out_sel),  32'd1);
    check("lk_last2", 32'(bus.out_last), 32'd0);
    bus.in_last = 8'h02;
    tick();
    check("lk_sel3",  32'(bus.out_sel),  32'd1);
    check("lk_last3", 32'(bus.out_last), 32'd1);
    check("lk_ready3", 32'(bus.in_ready), 32'h04);
    bus.in_valid = 8'h04;
    bus.in_last  = 8'h04;
    tick();
    check("lk_sel_ch2",  32'(bus.out_sel),  32'd2);
    check("lk_data_ch2", 32'(bus.out_data), 32'h12);
    check("lk_last_ch2", 32'(bus.out_last), 32'd1);
    bus.in_valid = 8'h00;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
